// File: rtl/complex_accumulator_param.sv
// complex_accumulator_param
//
// Framed accumulator for complex fixed-point samples. Samples of one frame
// (first flagged by start, last by stop) are summed into an ADD_LAT-deep
// feedback ring, so each ring slot holds the partial sum of every
// ADD_LAT-th sample. After the last sample the ring is drained for ADD_LAT
// cycles into a reduction register, and the frame sum is presented with a
// one-cycle out_valid pulse.
//
// Optional feature macro: ACCUM_SATURATE_EN
//   defined     - ring and reduction adders clamp per component; overflow
//                 reports whether any clamp happened during the frame.
//   not defined - adders wrap modulo 2^OW; overflow is tied low.
//
// Parameters:
//   WIDTH   signed bits per input component
//   GROW    guard bits; output/accumulator width OW = WIDTH + GROW
//   ADD_LAT feedback ring depth (pipelined adder latency), >= 1
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_r, in_i          signed input sample (WIDTH)
//   in_valid, in_ready  sample handshake; accepted = in_valid & in_ready
//   start, stop         first / last sample of a frame (with accepted in_valid)
//   out_r, out_i        signed frame sum (OW), held until next out_valid
//   out_valid           one-cycle result pulse
//   busy                high while accumulating or draining
//   overflow            frame result saturated (saturation build only)
module complex_accumulator_param #(
    parameter int WIDTH   = 16,
    parameter int GROW    = 8,
    parameter int ADD_LAT = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [WIDTH-1:0]      in_r,
    input  logic signed [WIDTH-1:0]      in_i,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         start,
    input  logic                         stop,
    output logic signed [WIDTH+GROW-1:0] out_r,
    output logic signed [WIDTH+GROW-1:0] out_i,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overflow
);

    localparam int OW = WIDTH + GROW;
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

`ifdef ACCUM_SATURATE_EN
    localparam logic signed [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Two's complement add of one component, wrapping or clamping.
    function automatic logic signed [OW-1:0] add_c(
        input logic signed [OW-1:0] a,
        input logic signed [OW-1:0] b
    );
        logic [OW:0] full;
        full = {a[OW-1], a} + {b[OW-1], b};
`ifdef ACCUM_SATURATE_EN
        if (full[OW] != full[OW-1])
            return full[OW] ? SAT_MIN : SAT_MAX;
`endif
        return full[OW-1:0];
    endfunction

`ifdef ACCUM_SATURATE_EN
    // True when a + b does not fit in OW bits.
    function automatic logic add_ovf(
        input logic signed [OW-1:0] a,
        input logic signed [OW-1:0] b
    );
        logic [OW:0] full;
        full = {a[OW-1], a} + {b[OW-1], b};
        return full[OW] != full[OW-1];
    endfunction
`endif

    state_t state;

    logic signed [OW-1:0] ring_r [ADD_LAT];
    logic signed [OW-1:0] ring_i [ADD_LAT];
    logic [ADD_LAT-1:0]   ring_v;

    logic signed [OW-1:0] red_r, red_i;
    logic [CW-1:0]        cnt;

    logic                 accepted, take_start, take_stop;
    logic signed [OW-1:0] in_ext_r, in_ext_i;
    logic signed [OW-1:0] acc_in_r, acc_in_i;
    logic signed [OW-1:0] head_r, head_i;
    logic signed [OW-1:0] sum_r, sum_i;
    logic signed [OW-1:0] red_sum_r, red_sum_i;
    logic signed [OW-1:0] wr_r, wr_i;
    logic                 wr_v, clear_v;

    assign in_ready   = (state != S_DRAIN);
    assign busy       = (state != S_IDLE);
    assign accepted   = in_valid & in_ready;
    assign take_start = accepted & start;
    assign take_stop  = accepted & stop;

    assign in_ext_r = OW'(in_r);
    assign in_ext_i = OW'(in_i);
    assign acc_in_r = accepted ? in_ext_r : '0;
    assign acc_in_i = accepted ? in_ext_i : '0;

    // Slots that were never written in this frame contribute zero.
    assign head_r = ring_v[ADD_LAT-1] ? ring_r[ADD_LAT-1] : '0;
    assign head_i = ring_v[ADD_LAT-1] ? ring_i[ADD_LAT-1] : '0;

    assign sum_r     = add_c(acc_in_r, head_r);
    assign sum_i     = add_c(acc_in_i, head_i);
    assign red_sum_r = add_c(red_r, head_r);
    assign red_sum_i = add_c(red_i, head_i);

    // Ring write selection. A start (first frame or restart) discards every
    // older partial sum by clearing the valid bits as they shift.
    always_comb begin
        wr_r    = '0;
        wr_i    = '0;
        wr_v    = 1'b0;
        clear_v = 1'b0;
        case (state)
            S_IDLE: begin
                if (take_start) begin
                    wr_r    = in_ext_r;
                    wr_i    = in_ext_i;
                    wr_v    = 1'b1;
                    clear_v = 1'b1;
                end
            end
            S_ACC: begin
                wr_v = 1'b1;
                if (take_start) begin
                    wr_r    = in_ext_r;
                    wr_i    = in_ext_i;
                    clear_v = 1'b1;
                end else begin
                    wr_r = sum_r;
                    wr_i = sum_i;
                end
            end
            default: ;
        endcase
    end

    // Ring data: advances every cycle, value written now is head L cycles later.
    always_ff @(posedge clk) begin
        ring_r[0] <= wr_r;
        ring_i[0] <= wr_i;
        for (int k = 1; k < ADD_LAT; k++) begin
            ring_r[k] <= ring_r[k-1];
            ring_i[k] <= ring_i[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_v <= '0;
        end else begin
            ring_v[0] <= wr_v;
            for (int k = 1; k < ADD_LAT; k++)
                ring_v[k] <= ring_v[k-1] & ~clear_v;
        end
    end

`ifdef ACCUM_SATURATE_EN
    logic frame_ovf;
    logic ovf_ring, ovf_red;

    assign ovf_ring = (state == S_ACC) && !take_start &&
                      (add_ovf(acc_in_r, head_r) || add_ovf(acc_in_i, head_i));
    assign ovf_red  = (state == S_DRAIN) &&
                      (add_ovf(red_r, head_r) || add_ovf(red_i, head_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_ovf <= 1'b0;
            overflow  <= 1'b0;
        end else if (take_start) begin
            frame_ovf <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_ovf <= frame_ovf | ovf_ring | ovf_red;
            if (state == S_DRAIN && cnt == CW'(ADD_LAT - 1))
                overflow <= frame_ovf | ovf_red;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    // Frame control and reduction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            red_r     <= '0;
            red_i     <= '0;
            cnt       <= '0;
            out_r     <= '0;
            out_i     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE, S_ACC: begin
                    if (take_start) begin
                        state <= take_stop ? S_DRAIN : S_ACC;
                        cnt   <= '0;
                        red_r <= '0;
                        red_i <= '0;
                    end else if (state == S_ACC && take_stop) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                        red_r <= '0;
                        red_i <= '0;
                    end
                end
                S_DRAIN: begin
                    red_r <= red_sum_r;
                    red_i <= red_sum_i;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(ADD_LAT - 1)) begin
                        out_r     <= red_sum_r;
                        out_i     <= red_sum_i;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_accumulator_param.sv
module tb_complex_accumulator_param;

    localparam int L  = 11;
    localparam int W  = 16;
    localparam int G  = 8;
    localparam int OW = W + G;
    localparam int G2 = 1;
    localparam int OW2 = W + G2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance (GROW = 8)
    logic signed [W-1:0]  in_r, in_i;
    logic                 in_valid, in_ready, start, stop;
    logic signed [OW-1:0] out_r, out_i;
    logic                 out_valid, busy, overflow;

    complex_accumulator_param #(.WIDTH(W), .GROW(G), .ADD_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .in_r(in_r), .in_i(in_i), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .stop(stop),
        .out_r(out_r), .out_i(out_i), .out_valid(out_valid),
        .busy(busy), .overflow(overflow)
    );

    // Narrow-guard instance (GROW = 1) for the wrap / clamp boundary
    logic signed [W-1:0]   s_in_r, s_in_i;
    logic                  s_in_valid, s_in_ready, s_start, s_stop;
    logic signed [OW2-1:0] s_out_r, s_out_i;
    logic                  s_out_valid, s_busy, s_overflow;

    complex_accumulator_param #(.WIDTH(W), .GROW(G2), .ADD_LAT(L)) dut2 (
        .clk(clk), .reset(reset),
        .in_r(s_in_r), .in_i(s_in_i), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .start(s_start), .stop(s_stop),
        .out_r(s_out_r), .out_i(s_out_i), .out_valid(s_out_valid),
        .busy(s_busy), .overflow(s_overflow)
    );

    typedef struct {
        int     n;
        int     br, sr, bi, si;   // sample k = (br + sr*k, bi + si*k)
        int     gap;              // 0: none, else bubble when cycle%gap == gap-1
        longint er, ei;
    } vec_t;

    typedef struct {
        longint r, i;
        bit     ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int i, input bit s, input bit e);
        in_valid = 1'b1;
        in_r     = W'(r);
        in_i     = W'(i);
        start    = s;
        stop     = e;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    // Drives one frame, then throws start/stop junk at the block during the
    // drain (must be dropped) and checks the result against the scoreboard.
    task automatic run_frame(input vec_t v, input string nm);
        int   k, cyc, lat;
        exp_t e;
        k = 0;
        cyc = 0;
        while (k < v.n) begin
            if (v.gap != 0 && (cyc % v.gap) == v.gap - 1) begin
                in_valid = 1'b0;
                start    = 1'b0;
                stop     = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_r     = W'(v.br + v.sr * k);
                in_i     = W'(v.bi + v.si * k);
                start    = (k == 0);
                stop     = (k == v.n - 1);
                k++;
            end
            tick();
            cyc++;
        end
        sb.push_back('{r: v.er, i: v.ei, ovf: 1'b0});
        chk({nm, " drain in_ready"}, in_ready, 0);
        chk({nm, " drain busy"}, busy, 1);
        lat = 1;
        while (!out_valid && lat <= L + 4) begin
            if (lat <= L) begin
                in_valid = 1'b1;
                in_r     = 16'sd999;
                in_i     = -16'sd999;
                start    = 1'b1;
                stop     = 1'b1;
            end else begin
                in_valid = 1'b0;
                start    = 1'b0;
                stop     = 1'b0;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        chk({nm, " latency"}, lat, L + 1);
        if (sb.size() == 0) begin
            chk({nm, " scoreboard"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({nm, " out_r"}, out_r, e.r);
            chk({nm, " out_i"}, out_i, e.i);
            chk({nm, " busy at out_valid"}, busy, 0);
            chk({nm, " overflow"}, overflow, e.ovf);
        end
    endtask

    initial begin
        int lat, nv;

        vecs[0] = '{n: 20, br: 1,    sr: 1,  bi: -1, si: -1, gap: 0, er: 210,     ei: -210};
        vecs[1] = '{n: 1,  br: 5,    sr: 0,  bi: 3,  si: 0,  gap: 0, er: 5,       ei: 3};
        vecs[2] = '{n: 3,  br: 1,    sr: 0,  bi: 1,  si: 0,  gap: 0, er: 3,       ei: 3};
        vecs[3] = '{n: 30, br: 1,    sr: 0,  bi: 0,  si: 0,  gap: 3, er: 30,      ei: 0};
        vecs[4] = '{n: 25, br: -100, sr: 10, bi: 7,  si: 0,  gap: 0, er: 500,     ei: 175};
        vecs[5] = '{n: 15, br: 2,    sr: 0,  bi: 2,  si: 0,  gap: 0, er: 30,      ei: 30};
        vecs[6] = '{n: 40, br: 32767, sr: 0, bi: -32768, si: 0, gap: 5, er: 1310680, ei: -1310720};

        reset = 1'b1;
        in_valid = 1'b0; in_r = '0; in_i = '0; start = 1'b0; stop = 1'b0;
        s_in_valid = 1'b0; s_in_r = '0; s_in_i = '0; s_start = 1'b0; s_stop = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;

        chk("reset out_r", out_r, 0);
        chk("reset out_i", out_i, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset overflow", overflow, 0);
        chk("reset in_ready", in_ready, 1);

        // Table frames, issued back-to-back: each next start lands in the
        // previous frame's out_valid cycle.
        for (int v = 0; v < 7; v++)
            run_frame(vecs[v], $sformatf("vec%0d", v));

        // Back-to-back with a different frame B right after (2,2)x15
        run_frame(vecs[5], "b2b_A");
        run_frame('{n: 12, br: 3, sr: 0, bi: -1, si: 0, gap: 0, er: 36, ei: -12}, "b2b_B");

        // Restart: partial frame of (100,0)x8, then a new start
        tick();
        send(100, 0, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) send(100, 0, 1'b0, 1'b0);
        run_frame('{n: 4, br: 1, sr: 0, bi: 0, si: 0, gap: 0, er: 4, ei: 0}, "restart");

        // Reset mid-ACC: frame is discarded, outputs cleared
        tick();
        send(7, 7, 1'b1, 1'b0);
        for (int k = 1; k < 5; k++) send(7, 7, 1'b0, 1'b0);
        chk("pre-reset busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset out_r", out_r, 0);
        chk("midreset out_i", out_i, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset busy", busy, 0);
        chk("midreset overflow", overflow, 0);
        nv = 0;
        for (int c = 0; c < 2 * L; c++) begin
            if (out_valid) nv++;
            tick();
        end
        chk("midreset no out_valid", nv, 0);
        run_frame(vecs[2], "after_reset");

        // Narrow guard: (32767,0)x4 in OW = 17
        tick();
        for (int k = 0; k < 4; k++) begin
            s_in_valid = 1'b1;
            s_in_r     = 16'sd32767;
            s_in_i     = 16'sd0;
            s_start    = (k == 0);
            s_stop     = (k == 3);
            tick();
        end
        s_in_valid = 1'b0; s_start = 1'b0; s_stop = 1'b0;
        lat = 1;
        while (!s_out_valid && lat <= L + 4) begin
            tick();
            lat++;
        end
        chk("narrow latency", lat, L + 1);
`ifdef ACCUM_SATURATE_EN
        chk("narrow out_r", s_out_r, 65535);
        chk("narrow overflow", s_overflow, 1);
`else
        chk("narrow out_r", s_out_r, -4);
        chk("narrow overflow", s_overflow, 0);
`endif
        chk("narrow out_i", s_out_i, 0);
        chk("narrow busy", s_busy, 0);

        chk("scoreboard empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
